decoder_cfg_loader: RTL

Frame parser that sits directly upstream of the Dock address decoder's configuration port. It accepts a byte stream from the Dock management MCU over a valid/ready interface and converts framed write commands into single-cycle `cfg_we`/`cfg_addr`/`cfg_wdata` strobes for the decoder's window tables: BASE, MASK, SLOT and OP. It rejects writes that would reach the IRQ configuration region. It optionally stages a whole frame and commits it only after a checksum verifies, so that partially applied window tables never occur.

---
 rtl/decoder_cfg_pkg.sv | 32 +++
 rtl/cfg_stage_buf.sv | 35 +++
 rtl/decoder_cfg_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_cfg_pkg.sv
// Shared definitions for the Dock address-decoder configuration loader.
// Contents: frame SYNC byte, loader state enum, error codes, default IRQ
// configuration base and the decoder cfg-map window offsets.
package decoder_cfg_pkg;

  localparam int unsigned CFG_DW = 8;

  localparam logic [7:0] SYNC_BYTE            = 8'hA5;
  localparam logic [7:0] IRQ_CFG_BASE_DEFAULT = 8'hC0;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ZERO_LEN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_CSUM     = 2'b11;

  // Window table offsets in the decoder cfg map (all below IRQ_CFG_BASE_DEFAULT)
  localparam logic [7:0] CFG_BASE_OFS = 8'h00;
  localparam logic [7:0] CFG_MASK_OFS = 8'h30;
  localparam logic [7:0] CFG_SLOT_OFS = 8'h60;
  localparam logic [7:0] CFG_OP_OFS   = 8'h90;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StData,
    StDrain,
    StCsum,
    StCommit
  } loader_state_e;

endpackage

// File: rtl/cfg_stage_buf.sv
// Staging register file holding one frame's data bytes until the checksum
// has been verified. One synchronous write port, one asynchronous read port.
// Ports:
//   cfg_clk  - clock
//   i_we     - write enable
//   i_waddr  - write index
//   i_wdata  - write byte
//   i_raddr  - read index
//   o_rdata  - read byte (combinational)
module cfg_stage_buf
  import decoder_cfg_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic              cfg_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [CFG_DW-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [CFG_DW-1:0] o_rdata
);

  logic [CFG_DW-1:0] r_mem [DEPTH];

  // Contents need no reset: a frame is always fully written before it is read.
  always_ff @(posedge cfg_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/decoder_cfg_loader.sv
// Byte-stream frame parser feeding the address decoder's configuration port.
// Frame: SYNC(A5), ADDR, LEN, LEN data bytes [, CSUM].
// Build option: DECODER_CFG_LOADER_CSUM_EN stages the frame and writes it out
// only after the trailing checksum byte verifies.
// Ports:
//   cfg_clk      - clock, rising edge
//   rst_n        - asynchronous reset, active HIGH despite the name
//   i_in_valid / o_in_ready / i_in_data - upstream byte stream
//   o_cfg_we / o_cfg_addr / o_cfg_wdata - one-cycle decoder write strobe
//   o_busy       - parser not idle
//   o_done       - frame completed pulse
//   o_err        - frame rejected pulse
//   o_err_code   - reason of last rejection (held)
module decoder_cfg_loader
  import decoder_cfg_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  IRQ_CFG_BASE = IRQ_CFG_BASE_DEFAULT
) (
  input  logic       cfg_clk,
  input  logic       rst_n,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [7:0] i_in_data,
  output logic       o_cfg_we,
  output logic [7:0] o_cfg_addr,
  output logic [7:0] o_cfg_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_err_code
);

  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);
`ifdef DECODER_CFG_LOADER_CSUM_EN
  localparam logic [8:0]  TRAIL_BYTES = 9'd1;
  localparam int unsigned IDX_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
`else
  localparam logic [8:0]  TRAIL_BYTES = 9'd0;
`endif

  loader_state_e r_state;
  logic [7:0]    r_cur_addr;
  logic [8:0]    r_cnt;
  logic          r_we;
  logic [7:0]    r_addr;
  logic [7:0]    r_wdata;
  logic          r_done;
  logic          r_err;
  logic [1:0]    r_err_code;

  logic          w_accept;
  logic [8:0]    w_last_addr;
  logic          w_range_bad;

`ifdef DECODER_CFG_LOADER_CSUM_EN
  logic [7:0]       r_len;
  logic [7:0]       r_sum;
  logic [IDX_W-1:0] r_idx;
  logic             w_buf_we;
  logic [IDX_W-1:0] w_raddr;
  logic [7:0]       w_rdata;
  logic [7:0]       w_csum_total;

  assign o_in_ready   = (r_state != StCommit);
  assign w_buf_we     = (r_state == StData) && w_accept;
  // CSUM state pre-reads slot 0 so the first write goes out right after CSUM.
  assign w_raddr      = (r_state == StCsum) ? '0 : r_idx;
  assign w_csum_total = r_sum + i_in_data;

  cfg_stage_buf #(
    .DEPTH (MAX_LEN),
    .IDX_W (IDX_W)
  ) u_stage_buf (
    .cfg_clk (cfg_clk),
    .i_we    (w_buf_we),
    .i_waddr (r_idx),
    .i_wdata (i_in_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );
`else
  logic r_done_pend;

  assign o_in_ready = 1'b1;
`endif

  assign w_accept = i_in_valid && o_in_ready;

  // 9-bit end address so a window wrapping past FF is caught as out of range.
  assign w_last_addr = {1'b0, r_cur_addr} + {1'b0, i_in_data} - 9'd1;
  assign w_range_bad = ({1'b0, i_in_data} > MAX_LEN_W) ||
                       (w_last_addr >= {1'b0, IRQ_CFG_BASE});

  always_ff @(posedge cfg_clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= StIdle;
      r_cur_addr  <= 8'h00;
      r_cnt       <= 9'd0;
      r_we        <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
`ifdef DECODER_CFG_LOADER_CSUM_EN
      r_len       <= 8'h00;
      r_sum       <= 8'h00;
      r_idx       <= '0;
`else
      r_done_pend <= 1'b0;
`endif
    end else begin
      r_we  <= 1'b0;
      r_err <= 1'b0;
`ifdef DECODER_CFG_LOADER_CSUM_EN
      r_done <= 1'b0;
`else
      r_done      <= r_done_pend;
      r_done_pend <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (w_accept && (i_in_data == SYNC_BYTE)) begin
            r_state <= StAddr;
          end
        end
        StAddr: begin
          if (w_accept) begin
            r_cur_addr <= i_in_data;
`ifdef DECODER_CFG_LOADER_CSUM_EN
            r_sum      <= i_in_data;
`endif
            r_state    <= StLen;
          end
        end
        StLen: begin
          if (w_accept) begin
            if (i_in_data == 8'h00) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_ZERO_LEN;
              r_state    <= StIdle;
            end else if (w_range_bad) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_RANGE;
              r_cnt      <= {1'b0, i_in_data} + TRAIL_BYTES;
              r_state    <= StDrain;
            end else begin
              r_cnt      <= {1'b0, i_in_data};
`ifdef DECODER_CFG_LOADER_CSUM_EN
              r_len      <= i_in_data;
              r_sum      <= r_sum + i_in_data;
              r_idx      <= '0;
`endif
              r_state    <= StData;
            end
          end
        end
        StData: begin
          if (w_accept) begin
            r_cnt <= r_cnt - 9'd1;
`ifdef DECODER_CFG_LOADER_CSUM_EN
            r_sum <= r_sum + i_in_data;
            r_idx <= r_idx + 1'b1;
            if (r_cnt == 9'd1) begin
              r_state <= StCsum;
            end
`else
            r_we       <= 1'b1;
            r_addr     <= r_cur_addr;
            r_wdata    <= i_in_data;
            r_cur_addr <= r_cur_addr + 8'd1;
            if (r_cnt == 9'd1) begin
              r_done_pend <= 1'b1;
              r_state     <= StIdle;
            end
`endif
          end
        end
        StDrain: begin
          if (w_accept) begin
            r_cnt <= r_cnt - 9'd1;
            if (r_cnt == 9'd1) begin
              r_state <= StIdle;
            end
          end
        end
`ifdef DECODER_CFG_LOADER_CSUM_EN
        StCsum: begin
          if (w_accept) begin
            if (w_csum_total == 8'h00) begin
              // First write issues here; COMMIT handles the remaining LEN-1.
              r_we       <= 1'b1;
              r_addr     <= r_cur_addr;
              r_wdata    <= w_rdata;
              r_cur_addr <= r_cur_addr + 8'd1;
              r_idx      <= IDX_W'(1);
              r_cnt      <= {1'b0, r_len} - 9'd1;
              r_state    <= StCommit;
            end else begin
              r_err      <= 1'b1;
              r_err_code <= ERR_CSUM;
              r_state    <= StIdle;
            end
          end
        end
        StCommit: begin
          if (r_cnt != 9'd0) begin
            r_we       <= 1'b1;
            r_addr     <= r_cur_addr;
            r_wdata    <= w_rdata;
            r_cur_addr <= r_cur_addr + 8'd1;
            r_idx      <= r_idx + 1'b1;
            r_cnt      <= r_cnt - 9'd1;
          end else begin
            // Leave COMMIT together with done so in_ready rises with it.
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_cfg_we    = r_we;
  assign o_cfg_addr  = r_addr;
  assign o_cfg_wdata = r_wdata;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;

endmodule
